apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first.
- Hclk  in  1  single clock; all state updates on its rising edge
- Hreset  in  1  synchronous active-high reset
- Psel  in  1  slave select (one bit of the bridge's Pselx)
- Penable  in  1  APB access-phase strobe
- Pwrite  in  1  1 = write, 0 = read
- Paddr  in  32  byte address; only [5:2] decoded (word index 0-15)
- Pwdata  in  32  write data
- Prdata  out  32  read data, registered
- Perr  out  1  sticky protocol-error flag
- Irq  out  1  interrupt, level, registered
REQ-002 SHALL implement APB2 protocol: no Pready and no Pslverr; every access completes in exactly one access cycle.

Function
REQ-003 Phase tracker states SHALL be IDLE, SETUP and ACCESS, updated each edge from the sampled inputs.
- !Psel -> IDLE
- Psel & !Penable -> SETUP
- Psel & Penable & state==SETUP -> ACCESS
- Psel & Penable & state!=SETUP -> IDLE, and Perr set
REQ-004 On entering SETUP, the block SHALL latch Paddr[5:2] and Pwrite as setup_idx and setup_wr.
REQ-005 An access is valid when state==SETUP and the edge samples Psel & Penable with Paddr[5:2]==setup_idx and Pwrite==setup_wr.
- Any mismatch: set Perr, discard the transfer, no count increment.
REQ-006 Register map by word index:
- 0-13: 32-bit RW general registers
- 14: STATUS, read-only; [15:0] wcnt, [31:16] rcnt
- 15: CTRL; bit0 irq_en (RW); bit1 clr (W1, self-clearing, reads 0); bit2 irq_clr (W1, self-clearing, reads 0); bits [31:3] read 0
REQ-007 Valid write SHALL commit Pwdata at the access edge (zero wait).
- Writes to STATUS change no data but still count.
REQ-008 Read data path:
- On the edge entering SETUP with Pwrite=0, Prdata SHALL load the addressed value, so it is valid throughout the following access cycle.
- On every other edge, Prdata SHALL load 0.
- Read latency: data is presented one cycle after the setup-phase edge.
REQ-009 Counters SHALL update at the access edge.
- wcnt increments on each valid write; rcnt increments on each valid read.
- Both are 16-bit and wrap 0xFFFF -> 0x0000.
- A STATUS read returns the pre-increment counts.
REQ-010 Clear behaviour: a valid CTRL write with bit1=1 SHALL zero wcnt, rcnt and Perr.
- Clear has priority, so the clearing write itself is not counted.
- irq_en still takes Pwdata[0] from that write.
REQ-011 Interrupt control:
- A valid write to word 0 while irq_en=1 SHALL set Irq at that edge.
- A valid CTRL write with bit2=1 SHALL clear Irq.
- Clearing irq_en SHALL NOT clear a pending Irq.
REQ-012 Perr SHALL be sticky: it stays 1 until a clear (REQ-010) or reset.
- An illegal access never writes or counts.
REQ-013 Back-to-back transfers (ACCESS directly followed by SETUP) SHALL be legal with no idle cycle required.

Reset
REQ-014 On an edge with Hreset=1, the block SHALL force:
- state = IDLE
- registers 0-13 = 0, irq_en = 0, wcnt = 0, rcnt = 0
- Prdata = 0, Perr = 0, Irq = 0
- Reset overrides any concurrent access.
REQ-015 Reset asserted mid-transfer (in SETUP or ACCESS) SHALL abort the transfer with no commit.
- The first access after reset release requires a fresh SETUP.

Verification
REQ-016 Write/read:
- Write 0xDEADBEEF to 0x08, then read 0x08 -> Prdata=0xDEADBEEF in the access cycle, 0 in the next cycle; STATUS=0x0001_0001 when read afterwards.
REQ-017 Protocol error:
- Psel=1, Penable=1 from IDLE with Pwrite=1, addr 0x00 -> Perr=1, register 0 unchanged, wcnt=0.
- Then write CTRL=0x2 -> Perr=0, wcnt=0.
REQ-018 Address change:
- SETUP with addr 0x04, ACCESS with addr 0x0C, write 0x55 -> Perr=1; registers 1 and 3 stay 0.
REQ-019 Interrupt:
- Write CTRL=0x1, then write 0x1 to 0x00 -> Irq=1 after that edge.
- Write CTRL=0x0 -> Irq stays 1.
- Write CTRL=0x4 -> Irq=0.
REQ-020 Counter wrap:
- Preload wcnt to 0xFFFF via 65535 writes, then one more write -> STATUS[15:0]=0x0000.
- Back-to-back SETUP/ACCESS pairs with no idle cycle -> all complete with no Perr.
REQ-021 Reset mid-ACCESS:
- Assert Hreset during a write access to 0x10 -> register 4 = 0, all outputs 0.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB2 register slave with 14 general-purpose registers, a STATUS
// word holding write/read transfer counters, and a CTRL word for the
// interrupt enable, the counter/error clear and the interrupt clear.
//
// Ports:
//   Hclk     in   clock; all state changes on its rising edge
//   Hreset   in   synchronous active-high reset
//   Psel     in   slave select
//   Penable  in   access-phase strobe
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   byte address; only [5:2] decoded (word index 0-15)
//   Pwdata   in   write data
//   Prdata   out  registered read data; valid only in a read's access cycle
//   Perr     out  sticky protocol-error flag
//   Irq      out  registered level interrupt
module apb_reg_slave (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Perr,
  output logic        Irq
);

  localparam int unsigned NUM_GP = 14;
  localparam logic [3:0]  IDX_REG0   = 4'd0;
  localparam logic [3:0]  IDX_STATUS = 4'd14;
  localparam logic [3:0]  IDX_CTRL   = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  setup_idx_q, setup_idx_d;
  logic        setup_wr_q, setup_wr_d;
  logic [31:0] regs_q [NUM_GP];
  logic [31:0] regs_d [NUM_GP];
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic        perr_q, perr_d;
  logic [31:0] prdata_q, prdata_d;

  logic [3:0]  idx;
  logic        enter_setup;
  logic        access_try;
  logic        valid;
  logic        proto_err;
  logic        vwr;
  logic        vrd;
  logic        clr;
  logic [31:0] rd_val;

  // Only word-index bits take part in decoding.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^{Paddr[31:6], Paddr[1:0]};

  assign idx         = Paddr[5:2];
  assign enter_setup = Psel & ~Penable;
  assign access_try  = Psel & Penable;

  // An access edge is only legal straight after SETUP and with the same
  // address/direction that was latched there; anything else is an error.
  assign valid     = access_try & (state_q == SETUP) &
                     (idx == setup_idx_q) & (Pwrite == setup_wr_q);
  assign proto_err = access_try & ~valid;
  assign vwr       = valid & setup_wr_q;
  assign vrd       = valid & ~setup_wr_q;
  assign clr       = vwr & (idx == IDX_CTRL) & Pwdata[1];

  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_STATUS: rd_val = {rcnt_q, wcnt_q};
      IDX_CTRL:   rd_val = {31'd0, irq_en_q};
      default:    rd_val = regs_q[idx];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    setup_idx_d = setup_idx_q;
    setup_wr_d  = setup_wr_q;
    regs_d      = regs_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    irq_en_d    = irq_en_q;
    irq_d       = irq_q;
    perr_d      = perr_q;
    prdata_d    = '0;

    if (!Psel) begin
      state_d = IDLE;
    end else if (!Penable) begin
      state_d = SETUP;
    end else if (state_q == SETUP) begin
      state_d = ACCESS;
    end else begin
      state_d = IDLE;
    end

    if (enter_setup) begin
      setup_idx_d = idx;
      setup_wr_d  = Pwrite;
      // Read data is fetched at the setup edge so it is stable for the
      // whole access cycle; every other edge returns the bus to zero.
      if (!Pwrite) prdata_d = rd_val;
    end

    if (vwr) begin
      if (idx < IDX_STATUS) regs_d[idx] = Pwdata;
      if ((idx == IDX_REG0) && irq_en_q) irq_d = 1'b1;
      if (idx == IDX_CTRL) begin
        irq_en_d = Pwdata[0];
        if (Pwdata[2]) irq_d = 1'b0;
      end
    end

    // Clear wins over counting, so the clearing write is not itself counted.
    if (clr) begin
      wcnt_d = '0;
      rcnt_d = '0;
      perr_d = 1'b0;
    end else begin
      if (vwr)       wcnt_d = wcnt_q + 16'd1;
      if (vrd)       rcnt_d = rcnt_q + 16'd1;
      if (proto_err) perr_d = 1'b1;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= IDLE;
      setup_idx_q <= '0;
      setup_wr_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_GP; i++) regs_q[i] <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      perr_q      <= 1'b0;
      prdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      setup_idx_q <= setup_idx_d;
      setup_wr_q  <= setup_wr_d;
      regs_q      <= regs_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      perr_q      <= perr_d;
      prdata_q    <= prdata_d;
    end
  end

  assign Prdata = prdata_q;
  assign Perr   = perr_q;
  assign Irq    = irq_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed and randomized bench for apb_reg_slave with a
// transaction-level register model.
module tb_apb_reg_slave;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Perr;
  logic        Irq;

  always #5 Hclk = ~Hclk;

  apb_reg_slave dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .Perr    (Perr),
    .Irq     (Irq)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: register contents and flags as seen by software.
  logic [31:0] m_regs [14];
  logic [15:0] m_wcnt;
  logic [15:0] m_rcnt;
  logic        m_irq_en;
  logic        m_irq;
  logic        m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_perr"}, {31'd0, Perr}, {31'd0, m_perr});
    check({tag, "_irq"},  {31'd0, Irq},  {31'd0, m_irq});
  endtask

  task automatic m_reset();
    for (int i = 0; i < 14; i++) m_regs[i] = '0;
    m_wcnt = '0; m_rcnt = '0;
    m_irq_en = 1'b0; m_irq = 1'b0; m_perr = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'd14) return {m_rcnt, m_wcnt};
    if (idx == 4'd15) return {31'd0, m_irq_en};
    return m_regs[idx];
  endfunction

  task automatic m_write(input logic [3:0] idx, input logic [31:0] data);
    if (idx < 4'd14) m_regs[idx] = data;
    if (idx == 4'd0 && m_irq_en) m_irq = 1'b1;
    if (idx == 4'd15) begin
      m_irq_en = data[0];
      if (data[2]) m_irq = 1'b0;
    end
    if (idx == 4'd15 && data[1]) begin
      m_wcnt = '0; m_rcnt = '0; m_perr = 1'b0;
    end else begin
      m_wcnt = m_wcnt + 16'd1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input logic [3:0] idx);
    logic [31:0] a;
    a = $urandom;
    a[5:2] = idx;
    return a;
  endfunction

  // All bus tasks start and end just after a falling edge.
  task automatic setup_phase(input logic [3:0] idx, input logic wr, input logic [31:0] data);
    Psel = 1'b1; Penable = 1'b0; Pwrite = wr;
    Paddr = rand_addr(idx); Pwdata = data;
    @(posedge Hclk); @(negedge Hclk);
  endtask

  task automatic apb_write(input logic [3:0] idx, input logic [31:0] data);
    setup_phase(idx, 1'b1, data);
    Penable = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    m_write(idx, data);
  endtask

  task automatic apb_read(input logic [3:0] idx, input string tag);
    logic [31:0] exp;
    exp = m_read(idx);
    setup_phase(idx, 1'b0, $urandom);
    check({tag, "_data"}, Prdata, exp);
    Penable = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    m_rcnt = m_rcnt + 16'd1;
    check({tag, "_after"}, Prdata, 32'd0);
  endtask

  task automatic idle_cycle();
    Psel = 1'b0; Penable = 1'b0;
    @(posedge Hclk); @(negedge Hclk);
  endtask

  task automatic proto_err();
    Psel = 1'b1; Penable = 1'b1; Pwrite = 1'($urandom);
    Paddr = $urandom; Pwdata = $urandom;
    @(posedge Hclk); @(negedge Hclk);
    m_perr = 1'b1;
  endtask

  task automatic mismatch(input logic [3:0] a, input logic wr, input logic change_addr);
    setup_phase(a, wr, $urandom);
    if (change_addr) Paddr = rand_addr(a ^ 4'($urandom_range(1, 15)));
    else             Pwrite = ~wr;
    Penable = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    m_perr = 1'b1;
  endtask

  task automatic do_reset();
    Hreset = 1'b1; Psel = 1'b0; Penable = 1'b0;
    @(posedge Hclk); @(posedge Hclk); @(negedge Hclk);
    Hreset = 1'b0;
    m_reset();
  endtask

  initial begin
    Hreset = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0;
    @(negedge Hclk);
    do_reset();
    check("rst_prdata", Prdata, 32'd0);
    check_flags("rst");

    // Write then read word 2; STATUS then shows one write and one read.
    apb_write(4'd2, 32'hDEADBEEF);
    apb_read(4'd2, "wr_rd");
    apb_read(4'd14, "status1");
    check_flags("wr_rd");

    // Access strobe without setup phase.
    idle_cycle();
    Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h0; Pwdata = 32'h1234_5678;
    @(posedge Hclk); @(negedge Hclk);
    m_perr = 1'b1;
    check_flags("proto");
    apb_read(4'd0, "proto_reg0");
    apb_write(4'd15, 32'h2);
    check_flags("clr");
    apb_read(4'd14, "clr_status");

    // Address changes between setup and access.
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h55;
    @(posedge Hclk); @(negedge Hclk);
    Penable = 1'b1; Paddr = 32'h0C;
    @(posedge Hclk); @(negedge Hclk);
    m_perr = 1'b1;
    check_flags("addr_chg");
    apb_read(4'd1, "addr_chg_r1");
    apb_read(4'd3, "addr_chg_r3");

    // Interrupt set, survives irq_en clear, cleared by irq_clr.
    apb_write(4'd15, 32'h1);
    apb_write(4'd0, 32'h1);
    check_flags("irq_set");
    apb_write(4'd15, 32'h0);
    check_flags("irq_hold");
    apb_write(4'd15, 32'h4);
    check_flags("irq_clr");
    apb_read(4'd15, "ctrl_rd");

    // Reset during a write access to word 4 with Irq and Perr pending.
    apb_write(4'd15, 32'h1);
    apb_write(4'd0, 32'hA5A5_A5A5);
    proto_err();
    check_flags("pre_rst");
    setup_phase(4'd4, 1'b1, 32'hCAFE_F00D);
    Penable = 1'b1; Hreset = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    Hreset = 1'b0; Psel = 1'b0; Penable = 1'b0;
    m_reset();
    check("midrst_prdata", Prdata, 32'd0);
    check_flags("midrst");
    apb_read(4'd4, "midrst_r4");
    apb_read(4'd0, "midrst_r0");
    apb_read(4'd14, "midrst_status");
    apb_write(4'd4, 32'h0BAD_CAFE);
    apb_read(4'd4, "post_rst_wr");

    // Randomized mix of legal and illegal traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [3:0]  idx;
      op  = $urandom_range(0, 9);
      idx = 4'($urandom);
      if (op <= 3)      apb_write(idx, $urandom);
      else if (op <= 6) apb_read(idx, "rnd_rd");
      else if (op == 7) idle_cycle();
      else if (op == 8) proto_err();
      else              mismatch(idx, 1'($urandom), 1'($urandom));
      check_flags("rnd");
    end
    for (int i = 0; i < 16; i++) apb_read(4'(i), "rnd_dump");

    // Counter wrap using back-to-back writes to STATUS.
    apb_write(4'd15, 32'h2);
    for (int n = 0; n < 65535; n++) apb_write(4'd14, $urandom);
    check_flags("b2b");
    apb_read(4'd14, "wrap_pre");
    apb_write(4'd14, 32'hFFFF_FFFF);
    apb_read(4'd14, "wrap_post");
    check_flags("wrap");
    idle_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
